// File: rtl/rs_dec_sched_16_8.sv
// RS(16,8) decoder sequencer: feeds the codeword FIFO and syndrome unit on ingress,
// then steps one codeword at a time through KES, Chien/Forney and read-out, keeping stats.
module rs_dec_sched_16_8 #(
    parameter int N_SYM   = 16,
    parameter int FIFO_CW = 2,
    parameter int SYN_LAT = 1,
    parameter int TMO_CYC = 255,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_sym,
    output logic              in_ready,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              syn_vld,
    output logic [DATA_W-1:0] syn_sym,
    output logic              syn_first,
    output logic              kes_start,
    input  logic              kes_done,
    input  logic              kes_fail,
    output logic              chien_start,
    input  logic              chien_done,
    output logic              rd_start,
    input  logic              rd_done,
    output logic              corr_en,
    output logic              busy,
    output logic              cw_done,
    output logic              cw_fail,
    output logic              tmo_err,
    output logic [15:0]       cw_total,
    output logic [15:0]       cw_fails
);

    localparam int IDX_W  = $clog2(N_SYM);
    localparam int BUF_W  = $clog2(FIFO_CW + 1);
    localparam int WAIT_W = $clog2(TMO_CYC + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_SYM - 1);
    localparam logic [BUF_W-1:0]  BUF_MAX  = BUF_W'(FIFO_CW);
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(TMO_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_KES   = 2'd1;
    localparam logic [1:0] S_CHIEN = 2'd2;
    localparam logic [1:0] S_READ  = 2'd3;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [IDX_W-1:0]  r_sym_idx;
    logic [BUF_W-1:0]  r_cw_buf;
    logic [SYN_LAT-1:0] r_lat;
    logic              r_syn_pend;
    logic              r_wr;
    logic              r_first;
    logic [DATA_W-1:0] r_sym_q;
    logic [1:0]        r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              r_fail;
    logic              r_corr_en;
    logic              r_kes_start;
    logic              r_chien_start;
    logic              r_rd_start;
    logic              r_cw_done;
    logic              r_cw_fail;
    logic              r_tmo_err;
    logic [15:0]       r_cw_total;
    logic [15:0]       r_cw_fails;

    logic w_ready;
    logic w_acc;
    logic w_last;
    logic w_kes_fire;
    logic w_tmo;
    logic w_retire;

    // Hold off symbol 0 of a new codeword while the previous syndromes await KES.
    assign w_ready    = (r_cw_buf < BUF_MAX) && !((r_sym_idx == '0) && r_syn_pend);
    assign w_acc      = in_valid && w_ready;
    assign w_last     = w_acc && (r_sym_idx == LAST_IDX);
    assign w_kes_fire = (r_state == S_IDLE) && r_syn_pend;
    assign w_tmo      = (r_wait == WAIT_END);
    assign w_retire   = (r_state == S_READ) && (rd_done || w_tmo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym_idx  <= '0;
            r_wr       <= 1'b0;
            r_first    <= 1'b0;
            r_sym_q    <= '0;
            r_lat      <= '0;
            r_syn_pend <= 1'b0;
            r_cw_buf   <= '0;
        end else begin
            r_wr    <= w_acc;
            r_first <= w_acc && (r_sym_idx == '0);
            if (w_acc) begin
                r_sym_q   <= in_sym;
                r_sym_idx <= (r_sym_idx == LAST_IDX) ? '0 : r_sym_idx + 1'b1;
            end
            r_lat[0] <= w_last;
            for (int i = 1; i < SYN_LAT; i++) begin
                r_lat[i] <= r_lat[i-1];
            end
            r_syn_pend <= r_lat[SYN_LAT-1] || (r_syn_pend && !w_kes_fire);
            case ({w_last, w_retire})
                2'b10:   r_cw_buf <= r_cw_buf + 1'b1;
                2'b01:   r_cw_buf <= r_cw_buf - 1'b1;
                default: r_cw_buf <= r_cw_buf;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wait        <= '0;
            r_fail        <= 1'b0;
            r_corr_en     <= 1'b0;
            r_kes_start   <= 1'b0;
            r_chien_start <= 1'b0;
            r_rd_start    <= 1'b0;
            r_cw_done     <= 1'b0;
            r_cw_fail     <= 1'b0;
            r_tmo_err     <= 1'b0;
            r_cw_total    <= '0;
            r_cw_fails    <= '0;
        end else begin
            r_kes_start   <= 1'b0;
            r_chien_start <= 1'b0;
            r_rd_start    <= 1'b0;
            r_cw_done     <= 1'b0;
            r_cw_fail     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    if (r_syn_pend) begin
                        r_kes_start <= 1'b1;
                        r_fail      <= 1'b0;
                        r_state     <= S_KES;
                    end
                end
                S_KES: begin
                    if (kes_done) begin
                        r_wait <= '0;
                        if (!kes_fail) begin
                            r_chien_start <= 1'b1;
                            r_state       <= S_CHIEN;
                        end else begin
                            r_fail     <= 1'b1;
                            r_corr_en  <= 1'b0;
                            r_rd_start <= 1'b1;
                            r_state    <= S_READ;
                        end
                    end else if (w_tmo) begin
                        r_wait     <= '0;
                        r_tmo_err  <= 1'b1;
                        r_fail     <= 1'b1;
                        r_corr_en  <= 1'b0;
                        r_rd_start <= 1'b1;
                        r_state    <= S_READ;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_CHIEN: begin
                    if (chien_done) begin
                        r_wait     <= '0;
                        r_corr_en  <= 1'b1;
                        r_rd_start <= 1'b1;
                        r_state    <= S_READ;
                    end else if (w_tmo) begin
                        r_wait     <= '0;
                        r_tmo_err  <= 1'b1;
                        r_fail     <= 1'b1;
                        r_corr_en  <= 1'b0;
                        r_rd_start <= 1'b1;
                        r_state    <= S_READ;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_READ: begin
                    // A read-out that never finishes is still retired, as a failure.
                    if (rd_done || w_tmo) begin
                        r_wait     <= '0;
                        r_cw_done  <= 1'b1;
                        r_cw_fail  <= r_fail || !rd_done;
                        r_corr_en  <= 1'b0;
                        r_cw_total <= sat_inc(r_cw_total);
                        if (r_fail || !rd_done) begin
                            r_cw_fails <= sat_inc(r_cw_fails);
                        end
                        if (!rd_done) begin
                            r_tmo_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = w_ready;
    assign fifo_wr     = r_wr;
    assign fifo_wdata  = r_sym_q;
    assign syn_vld     = r_wr;
    assign syn_sym     = r_sym_q;
    assign syn_first   = r_first;
    assign kes_start   = r_kes_start;
    assign chien_start = r_chien_start;
    assign rd_start    = r_rd_start;
    assign corr_en     = r_corr_en;
    assign busy        = (r_state != S_IDLE);
    assign cw_done     = r_cw_done;
    assign cw_fail     = r_cw_fail;
    assign tmo_err     = r_tmo_err;
    assign cw_total    = r_cw_total;
    assign cw_fails    = r_cw_fails;

endmodule
